// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one stb/ack barrel shifter among num_req requesters
module shift_arbiter #(
    parameter int data_width = 64,
    parameter int num_req    = 4,
    localparam int idx_w     = $clog2(num_req)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req_stb,
    input  logic [num_req-1:0]            req_arith,
    input  logic [num_req-1:0]            req_left,
    input  logic [num_req*data_width-1:0] req_value,
    input  logic [num_req*data_width-1:0] req_shift,
    output logic [data_width-1:0]         req_out,
    output logic [num_req-1:0]            req_ack,
    output logic                          busy,
    output logic [idx_w-1:0]              gnt_idx,
    output logic                          sh_stb,
    output logic                          sh_arith,
    output logic                          sh_left,
    output logic [data_width-1:0]         sh_value,
    output logic [data_width-1:0]         sh_shift,
    input  logic [data_width-1:0]         sh_out,
    input  logic                          sh_ack
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t                state_q, state_d;
    logic [idx_w-1:0]      ptr_q, ptr_d, gnt_q, gnt_d, win;
    logic                  sh_stb_q, sh_stb_d, arith_q, arith_d, left_q, left_d;
    logic [data_width-1:0] value_q, value_d, shift_q, shift_d, out_q, out_d;
    logic [num_req-1:0]    ack_q, ack_d;
    always_comb begin
        win = ptr_q;
        for (int k = num_req; k >= 1; k--)
            if (req_stb[(int'(ptr_q) + k) % num_req]) win = idx_w'((int'(ptr_q) + k) % num_req);
    end
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        sh_stb_d = sh_stb_q;
        arith_d  = arith_q;
        left_d   = left_q;
        value_d  = value_q;
        shift_d  = shift_q;
        out_d    = out_q;
        ack_d    = ack_q;
        unique case (state_q)
            IDLE: if (|req_stb) begin
                state_d  = ISSUE;
                ptr_d    = win;
                gnt_d    = win;
                sh_stb_d = 1'b1;
                arith_d  = req_arith[win];
                left_d   = req_left[win];
                value_d  = req_value[win*data_width +: data_width];
                shift_d  = req_shift[win*data_width +: data_width];
            end
            ISSUE: begin
                sh_stb_d = 1'b0;
                state_d  = WAIT;
            end
            WAIT: if (sh_ack) begin
                out_d        = sh_out;
                ack_d[gnt_q] = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                ack_d   = '0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= idx_w'(num_req - 1);
            gnt_q    <= '0;
            sh_stb_q <= 1'b0;
            arith_q  <= 1'b0;
            left_q   <= 1'b0;
            value_q  <= '0;
            shift_q  <= '0;
            out_q    <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            sh_stb_q <= sh_stb_d;
            arith_q  <= arith_d;
            left_q   <= left_d;
            value_q  <= value_d;
            shift_q  <= shift_d;
            out_q    <= out_d;
            ack_q    <= ack_d;
        end
    end
    assign req_out  = out_q;
    assign req_ack  = ack_q;
    assign busy     = state_q != IDLE;
    assign gnt_idx  = gnt_q;
    assign sh_stb   = sh_stb_q;
    assign sh_arith = arith_q;
    assign sh_left  = left_q;
    assign sh_value = value_q;
    assign sh_shift = shift_q;
endmodule
